// File: rtl/interrupt_controller_if.sv
// Core-side bus of the interrupt controller: return PC / SP in, stack push,
// fetch stall and PC overwrite out. master = controller, slave = CPU core.
interface interrupt_controller_if;
  logic [13:0] pc;
  logic [15:0] sp;
  logic        hold;
  logic        stack_we;
  logic [15:0] stack_addr;
  logic [7:0]  stack_data;
  logic        sp_dec;
  logic        pc_overwrite;
  logic [13:0] pc_new;
  logic        sreg_i_clear;

  modport master (
    input  pc, sp,
    output hold, stack_we, stack_addr, stack_data, sp_dec,
           pc_overwrite, pc_new, sreg_i_clear
  );

  modport slave (
    output pc, sp,
    input  hold, stack_we, stack_addr, stack_data, sp_dec,
           pc_overwrite, pc_new, sreg_i_clear
  );
endinterface

// File: rtl/interrupt_controller.sv
// Timer interrupt arbiter and entry sequencer for the ATmega32A core.
// Define INTC_TIMER1_EN to arbitrate the Timer1 sources (OCF1A, TOV1) as well.
//
// state  | meaning
// IDLE   | waiting for an instruction boundary with an enabled pending source
// PUSH_L | push ret_pc[7:0] at sp, decrement sp
// PUSH_H | push ret_pc[13:8] at sp, decrement sp
// VECTOR | load PC with vector, clear I-bit and serviced TIFR flag
module interrupt_controller #(
  parameter logic [13:0] VEC_OCF1A = 14'h00E,
  parameter logic [13:0] VEC_TOV1  = 14'h012,
  parameter logic [13:0] VEC_OCF0  = 14'h014,
  parameter logic [13:0] VEC_TOV0  = 14'h016
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] tifr,
  input  logic [7:0] timsk,
  input  logic       sreg_i,
  input  logic       instr_boundary,
  input  logic       reti,
  output logic [7:0] flag_clear,
  output logic       irq_pending,
  interrupt_controller_if.master cpu
);

`ifdef INTC_TIMER1_EN
  localparam logic [7:0] SRC_MASK = 8'h17;
`else
  localparam logic [7:0] SRC_MASK = 8'h03;
`endif

  typedef enum logic [1:0] {IDLE, PUSH_L, PUSH_H, VECTOR} state_t;

  state_t      state, state_nxt;
  logic [7:0]  src;
  logic [13:0] sel_vec;
  logic [7:0]  sel_bit;
  logic        skip;
  logic        accept;
  logic [13:0] ret_pc;
  logic [13:0] vec_q;
  logic [7:0]  bit_q;

  assign src         = tifr & timsk & SRC_MASK;
  assign irq_pending = (|src) & sreg_i;
  // A boundary coinciding with RETI is never taken, even if skip was clear.
  assign accept      = (state == IDLE) & instr_boundary & irq_pending & ~skip & ~reti;

  always_comb begin
    sel_vec = VEC_TOV0;
    sel_bit = 8'h01;
    if (src[4]) begin
      sel_vec = VEC_OCF1A;
      sel_bit = 8'h10;
    end else if (src[2]) begin
      sel_vec = VEC_TOV1;
      sel_bit = 8'h04;
    end else if (src[1]) begin
      sel_vec = VEC_OCF0;
      sel_bit = 8'h02;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      skip   <= 1'b0;
      ret_pc <= '0;
      vec_q  <= '0;
      bit_q  <= '0;
    end else begin
      if (reti)
        skip <= 1'b1;
      else if (state == IDLE && instr_boundary && skip)
        skip <= 1'b0;
      if (accept) begin
        ret_pc <= cpu.pc;
        vec_q  <= sel_vec;
        bit_q  <= sel_bit;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = PUSH_L;
      PUSH_L:  state_nxt = PUSH_H;
      PUSH_H:  state_nxt = VECTOR;
      VECTOR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cpu.hold         = 1'b0;
    cpu.stack_we     = 1'b0;
    cpu.stack_addr   = '0;
    cpu.stack_data   = '0;
    cpu.sp_dec       = 1'b0;
    cpu.pc_overwrite = 1'b0;
    cpu.pc_new       = '0;
    cpu.sreg_i_clear = 1'b0;
    flag_clear       = '0;
    case (state)
      PUSH_L: begin
        cpu.hold       = 1'b1;
        cpu.stack_we   = 1'b1;
        cpu.stack_addr = cpu.sp;
        cpu.stack_data = ret_pc[7:0];
        cpu.sp_dec     = 1'b1;
      end
      PUSH_H: begin
        cpu.hold       = 1'b1;
        cpu.stack_we   = 1'b1;
        cpu.stack_addr = cpu.sp;
        cpu.stack_data = {2'b00, ret_pc[13:8]};
        cpu.sp_dec     = 1'b1;
      end
      VECTOR: begin
        cpu.hold         = 1'b1;
        cpu.pc_overwrite = 1'b1;
        cpu.pc_new       = vec_q;
        cpu.sreg_i_clear = 1'b1;
        flag_clear       = bit_q;
      end
      default: ;
    endcase
  end

endmodule
